// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared sizing defaults, arbiter state encoding and priority helper
package irq_arb_pkg;
  localparam int N_DEF = 32;
  localparam int IDW_DEF = 5;
  localparam int N_MAX = 64;
  localparam int IDW_MAX = 6;
  typedef enum logic {IDLE, PRESENT} state_t;
  // Highest set bit wins; an empty vector yields index 0.
  function automatic logic [IDW_MAX-1:0] highest_index(input logic [N_MAX-1:0] v);
    highest_index = '0;
    for (int i = 0; i < N_MAX; i++) if (v[i]) highest_index = IDW_MAX'(i);
  endfunction
endpackage

// File: rtl/irq_req_sync.sv
// irq_req_sync: two-flop synchronizer for active-low requests with assertion-edge detect
module irq_req_sync #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_n,
  output logic [N-1:0] sync2,
  output logic [N-1:0] fall
);
  logic [N-1:0] sync1, prev_n;
  // Everything resets high so a line held low across reset shows a fresh edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      prev_n <= '1;
    end else begin
      sync1  <= req_n;
      sync2  <= sync1;
      prev_n <= sync2;
    end
  assign fall = prev_n & ~sync2;
endmodule

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: latches synchronized requests as pending and presents the
// highest eligible index over a valid/ready handshake, clearing it on acceptance.
module irq_pending_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDW = IDW_DEF,
  parameter int EDGE_MODE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_n,
  input  logic [N-1:0]   mask,
  input  logic           en,
  input  logic           vec_ready,
  output logic           vec_valid,
  output logic [IDW-1:0] vec_id,
  output logic           pend_any
);
  state_t state, state_nx;
  logic [N-1:0] sync2, fall, pending, pending_nx, elig, clr;
  logic [IDW-1:0] winner;
  logic accept;
  irq_req_sync #(.N(N)) u_sync (.clk(clk), .rst(rst), .req_n(req_n), .sync2(sync2), .fall(fall));
  assign accept = vec_valid & vec_ready;
  assign elig = pending & ~mask & {N{en}};
  assign winner = IDW'(highest_index(N_MAX'(elig)));
  assign vec_valid = state == PRESENT;
  // Set is OR-ed after clear so an edge landing on the accept cycle survives.
  always_comb begin
    clr = accept ? N'(1) << vec_id : '0;
    pending_nx = EDGE_MODE != 0 ? (pending & ~clr) | fall : ~sync2;
    state_nx = state == IDLE ? (|elig ? PRESENT : IDLE) : (accept ? IDLE : PRESENT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      vec_id   <= '0;
      pend_any <= 1'b0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      pend_any <= |(pending & ~mask);
      if (state == IDLE && |elig) vec_id <= winner;
    end
endmodule
